condition_tracker: RTL and testbench
====================================

# condition_tracker

Parametrised next-generation physiological-condition block (illness, exhaustion, stress episodes). It owns a saturating condition accumulator driven by the regulator's inc/dec/fast/setval requests. It derives a debounced, hysteretic `active` flag with minimum-hold time, onset/recovery pulses and an episode count. It sits between a condition regulator and the behaviour/action logic, replacing fixed top-two-bit threshold decoding with parameterised thresholds.

## Interface
Parameters:
- WIDTH, 9: accumulator width.
- DEFAULT_VAL, 128: accumulator reset value.
- SET_VAL, 128: value loaded on `setval`.
- FAST_STEP, 4: step size when `fast`=1; normal step is 1.
- ENTER_THR, 384: a sample qualifies for onset when `level` >= ENTER_THR.
- EXIT_THR, 127: a sample qualifies for recovery when `level` <= EXIT_THR. Requires EXIT_THR < ENTER_THR.
- DWELL, 1: consecutive qualifying samples required for either transition. Must be >= 1.
- MIN_HOLD, 0: minimum cycles spent active before recovery samples count.
- EPI_W, 8: episode counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- inc  in  1  increment request.
- dec  in  1  decrement request.
- fast  in  1  use FAST_STEP instead of 1.
- setval  in  1  load SET_VAL; highest priority.
- clr_episodes  in  1  synchronous clear of `episodes`.
- level  out  WIDTH  accumulator value (registered).
- active  out  1  condition present.
- onset_p  out  1  one-cycle pulse when `active` rises.
- recover_p  out  1  one-cycle pulse when `active` falls.
- state  out  2  FSM state, for debug.
- episodes  out  EPI_W  saturating count of onsets.

## Operation
- Accumulator update, per cycle, in priority order:
  - `setval`: load SET_VAL.
  - `inc` and not `dec`: add step; saturate at 2^WIDTH-1.
  - `dec` and not `inc`: subtract step; saturate at 0.
  - Both or neither: hold.
- FSM states: IDLE=0, ONSET=1, ACTIVE=2, RECOVER=3. `active` = (state==ACTIVE or state==RECOVER).
- All FSM decisions use the registered `level`, sampled every cycle. `dcnt` counts consecutive qualifying samples.
- IDLE, onset-qualifying sample: DWELL==1 → ACTIVE; otherwise → ONSET with dcnt=1.
- ONSET:
  - Non-qualifying sample → IDLE, dcnt=0.
  - Qualifying sample with dcnt+1==DWELL → ACTIVE.
  - Otherwise dcnt++.
- On entering ACTIVE from IDLE/ONSET: hold counter `hcnt`=0, `onset_p`=1, `episodes`++ (saturating at 2^EPI_W-1).
- `hcnt` increments every cycle in ACTIVE/RECOVER and saturates at MIN_HOLD.
- ACTIVE: a recovery-qualifying sample is accepted only when hcnt >= MIN_HOLD. It then follows the same dwell rule, using RECOVER as the pending state.
- RECOVER:
  - Non-qualifying sample → ACTIVE, dcnt=0; `hcnt` is not reset.
  - Completing the dwell → IDLE with `recover_p`=1.
- `clr_episodes` zeroes the counter. If an onset occurs in the same cycle, the counter becomes 1.

## Timing
- Reset values: level=DEFAULT_VAL; state=IDLE; active, onset_p, recover_p, dcnt, hcnt = 0; episodes=0.
- `level` updates one cycle after the request.
- With DWELL=1, `active` rises one cycle after `level` first reaches ENTER_THR, i.e. two cycles after the causing inc. Each extra dwell sample adds one cycle. Recovery timing is symmetric.
- `onset_p`/`recover_p` are registered and coincide with the cycle `active` changes.
- Levels strictly between the thresholds never change `active`.
- `setval` mid-ONSET/RECOVER takes effect on `level` next cycle and is evaluated like any other sample.
- Reset asserted mid-episode returns all state to reset values immediately; no `recover_p` is emitted.

## Structure
- Shared package `condition_pkg`: FSM state localparams (IDLE/ONSET/ACTIVE/RECOVER) and the 2-bit state type.
- Sub-module `sat_accumulator`: the saturating WIDTH-bit counter with setval/fast. It replaces the existing fixed-width neurotransmitter-level counter for this block.
- FSM, dwell/hold counters and episode counter live in `condition_tracker`. Counter widths are $clog2(DWELL+1) and $clog2(MIN_HOLD+1), each with a minimum of 1.

## Test plan
- Reset, then no requests: level=128, active=0, episodes=0. Then inc+fast held from 380 (reached by setval/inc): level 380→384 → active=1 one cycle later, onset_p single pulse, episodes=1.
- Saturation: 200 cycles of inc+fast → level stops at 511. 200 cycles of dec → level stops at 0. inc+dec together → level holds.
- DWELL=3: level toggles 384,383 repeatedly → never active. Three consecutive samples ≥384 → active rises on the 4th edge.
- MIN_HOLD=10: enter active, then dec+fast to 100 immediately → active stays 1 until 10 active cycles elapse (plus dwell), then falls with recover_p.
- Hysteresis: level parked at 200 after an onset → active stays 1 indefinitely. Park at 200 from IDLE → stays 0.
- Reset asserted while in RECOVER, and episodes saturation: 256 onsets with EPI_W=8 → episodes=255. clr_episodes during an onset cycle → episodes=1.

Source files
------------

// File: rtl/condition_pkg.sv
// Shared types for the condition tracker: FSM state encoding and a counter-width helper.
package condition_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ONSET   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // Bits needed to count 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Saturating WIDTH-bit condition accumulator: setval load, inc/dec by 1 or FAST_STEP.
module sat_accumulator #(
    parameter int WIDTH       = 9,
    parameter int DEFAULT_VAL = 128,
    parameter int SET_VAL     = 128,
    parameter int FAST_STEP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    input  logic             setval,
    output logic [WIDTH-1:0] level
);

    localparam logic [WIDTH:0]   MAX_L  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   FAST_L = (WIDTH + 1)'(FAST_STEP);
    localparam logic [WIDTH:0]   ONE_L  = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] SET_L  = WIDTH'(SET_VAL);
    localparam logic [WIDTH-1:0] DEF_L  = WIDTH'(DEFAULT_VAL);

    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] next_level;

    // One spare bit on the sum exposes overflow so saturation is a plain compare.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        step       = fast ? FAST_L : ONE_L;
        sum        = {1'b0, level} + step;
        next_level = level;
        if (setval) begin
            next_level = SET_L;
        end else if (inc && !dec) begin
            next_level = (sum > MAX_L) ? MAX_L[WIDTH-1:0] : sum[WIDTH-1:0];
        end else if (dec && !inc) begin
            next_level = ({1'b0, level} < step) ? '0 : level - step[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level <= DEF_L;
        else        level <= next_level;
    end

endmodule

// File: rtl/condition_tracker.sv
// Condition accumulator plus debounced, hysteretic active flag with minimum hold,
// onset/recovery pulses and a saturating episode count.
module condition_tracker
    import condition_pkg::*;
#(
    parameter int WIDTH       = 9,
    parameter int DEFAULT_VAL = 128,
    parameter int SET_VAL     = 128,
    parameter int FAST_STEP   = 4,
    parameter int ENTER_THR   = 384,
    parameter int EXIT_THR    = 127,
    parameter int DWELL       = 1,
    parameter int MIN_HOLD    = 0,
    parameter int EPI_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    input  logic             setval,
    input  logic             clr_episodes,
    output logic [WIDTH-1:0] level,
    output logic             active,
    output logic             onset_p,
    output logic             recover_p,
    output logic [1:0]       state,
    output logic [EPI_W-1:0] episodes
);

    localparam int DW = cnt_w(DWELL);
    localparam int HW = cnt_w(MIN_HOLD);

    localparam logic [WIDTH-1:0] ENTER_L  = WIDTH'(ENTER_THR);
    localparam logic [WIDTH-1:0] EXIT_L   = WIDTH'(EXIT_THR);
    localparam logic [DW-1:0]    DWELL_M1 = DW'(DWELL - 1);
    localparam logic [HW-1:0]    HOLD_L   = HW'(MIN_HOLD);

    state_t          state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            onset_d, recover_d;
    logic            qual_on, qual_off, last_sample, hold_met;

    sat_accumulator #(
        .WIDTH      (WIDTH),
        .DEFAULT_VAL(DEFAULT_VAL),
        .SET_VAL    (SET_VAL),
        .FAST_STEP  (FAST_STEP)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .dec   (dec),
        .fast  (fast),
        .setval(setval),
        .level (level)
    );

    assign qual_on     = (level >= ENTER_L);
    assign qual_off    = (level <= EXIT_L);
    assign last_sample = (dcnt_q == DWELL_M1);   // this sample completes the dwell
    assign hold_met    = (hcnt_q >= HOLD_L);

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        onset_d   = 1'b0;
        recover_d = 1'b0;
        if ((state_q == ACTIVE || state_q == RECOVER) && hcnt_q != HOLD_L)
            hcnt_d = hcnt_q + HW'(1);
        case (state_q)
            IDLE: begin
                dcnt_d = '0;
                hcnt_d = '0;
                if (qual_on) begin
                    if (last_sample) begin
                        state_d = ACTIVE;
                        onset_d = 1'b1;
                    end else begin
                        state_d = ONSET;
                        dcnt_d  = DW'(1);
                    end
                end
            end
            ONSET: begin
                if (!qual_on) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (last_sample) begin
                    state_d = ACTIVE;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                    onset_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ACTIVE: begin
                if (qual_off && hold_met) begin
                    if (last_sample) begin
                        state_d   = IDLE;
                        dcnt_d    = '0;
                        recover_d = 1'b1;
                    end else begin
                        state_d = RECOVER;
                        dcnt_d  = dcnt_q + DW'(1);
                    end
                end
            end
            RECOVER: begin
                // A non-qualifying sample restarts the dwell but keeps the hold already served.
                if (!qual_off) begin
                    state_d = ACTIVE;
                    dcnt_d  = '0;
                end else if (last_sample) begin
                    state_d   = IDLE;
                    dcnt_d    = '0;
                    recover_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            onset_p   <= 1'b0;
            recover_p <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            onset_p   <= onset_d;
            recover_p <= recover_d;
        end
    end

    // Clear wins over counting, except that an onset in the same cycle still counts as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            episodes <= '0;
        else if (clr_episodes)
            episodes <= onset_d ? EPI_W'(1) : '0;
        else if (onset_d && episodes != {EPI_W{1'b1}})
            episodes <= episodes + EPI_W'(1);
    end

    assign active = (state_q == ACTIVE) || (state_q == RECOVER);
    assign state  = state_q;

endmodule

// File: tb/tb_condition_tracker.sv
// Scoreboarded bench: two tracker instances (fast-response and debounced/held) share stimulus
// and are compared every cycle against a behavioural model of the condition rules.
module tb_condition_tracker;

    typedef struct {
        int width, defv, setv, fstep, enter, exitt, dwell, hold, epiw;
    } prm_t;

    // Model view: active flag, length of the current run of qualifying samples,
    // samples taken since becoming active, and the episode count.
    typedef struct {
        int level;
        bit act;
        int run;
        int age;
        int epi;
        bit on_p;
        bit rec_p;
    } mdl_t;

    typedef struct {
        int idx;
        int level;
        int act;
        int on_p;
        int rec_p;
        int st;
        int epi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inc = 1'b0, dec = 1'b0, fast = 1'b0, setval = 1'b0, clr_episodes = 1'b0;

    logic [8:0] level_a, level_b;
    logic       active_a, active_b, onset_p_a, onset_p_b, recover_p_a, recover_p_b;
    logic [1:0] state_a, state_b;
    logic [7:0] episodes_a;
    logic [3:0] episodes_b;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    prm_t pa, pb;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    condition_tracker dut_a (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
        .clr_episodes(clr_episodes), .level(level_a), .active(active_a), .onset_p(onset_p_a),
        .recover_p(recover_p_a), .state(state_a), .episodes(episodes_a)
    );

    condition_tracker #(
        .EXIT_THR(380), .DWELL(3), .MIN_HOLD(10), .EPI_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
        .clr_episodes(clr_episodes), .level(level_b), .active(active_b), .onset_p(onset_p_b),
        .recover_p(recover_p_b), .state(state_b), .episodes(episodes_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t m_reset(input prm_t p);
        mdl_t m;
        m.level = p.defv; m.act = 0; m.run = 0; m.age = 0; m.epi = 0; m.on_p = 0; m.rec_p = 0;
        return m;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input prm_t p,
                                    input bit i, input bit d, input bit f, input bit s, input bit c);
        mdl_t n;
        int   lv, mx, st;
        n = m;
        lv = m.level;
        mx = (1 << p.width) - 1;
        st = f ? p.fstep : 1;
        n.on_p = 0;
        n.rec_p = 0;
        if (!m.act) begin
            n.run = (lv >= p.enter) ? m.run + 1 : 0;
            if (n.run == p.dwell) begin
                n.act = 1; n.run = 0; n.age = 0; n.on_p = 1;
            end
        end else begin
            n.run = (lv <= p.exitt && m.age >= p.hold) ? m.run + 1 : 0;
            n.age = m.age + 1;
            if (n.run == p.dwell) begin
                n.act = 0; n.run = 0; n.rec_p = 1;
            end
        end
        if (c)
            n.epi = n.on_p ? 1 : 0;
        else if (n.on_p && m.epi < (1 << p.epiw) - 1)
            n.epi = m.epi + 1;
        if (s)
            n.level = p.setv;
        else if (i && !d)
            n.level = (lv + st > mx) ? mx : lv + st;
        else if (d && !i)
            n.level = (lv - st < 0) ? 0 : lv - st;
        return n;
    endfunction

    function automatic exp_t to_exp(input int idx, input mdl_t m);
        exp_t e;
        e.idx = idx; e.level = m.level; e.act = m.act; e.on_p = m.on_p; e.rec_p = m.rec_p;
        e.epi = m.epi;
        e.st = !m.act ? (m.run == 0 ? 0 : 1) : (m.run == 0 ? 2 : 3);
        return e;
    endfunction

    // Monitor: every cycle the DUTs present their outputs; compare against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.idx == 0) begin
                    check("a.level", int'(level_a), e.level);
                    check("a.active", int'(active_a), e.act);
                    check("a.onset_p", int'(onset_p_a), e.on_p);
                    check("a.recover_p", int'(recover_p_a), e.rec_p);
                    check("a.state", int'(state_a), e.st);
                    check("a.episodes", int'(episodes_a), e.epi);
                end else begin
                    check("b.level", int'(level_b), e.level);
                    check("b.active", int'(active_b), e.act);
                    check("b.onset_p", int'(onset_p_b), e.on_p);
                    check("b.recover_p", int'(recover_p_b), e.rec_p);
                    check("b.state", int'(state_b), e.st);
                    check("b.episodes", int'(episodes_b), e.epi);
                end
            end
        end
    end

    task automatic cycle(input bit i, input bit d, input bit f, input bit s, input bit c);
        inc = i; dec = d; fast = f; setval = s; clr_episodes = c;
        @(posedge clk);
        ma = m_step(ma, pa, i, d, f, s, c);
        mb = m_step(mb, pb, i, d, f, s, c);
        sb.push_back(to_exp(0, ma));
        sb.push_back(to_exp(1, mb));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic ramp_up(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 1, 0, 0);
    endtask

    task automatic ramp_down(input int n);
        for (int k = 0; k < n; k++) cycle(0, 1, 1, 0, 0);
    endtask

    // Reset is asserted off-edge; the model returns to reset values at the same moment.
    task automatic do_reset();
        inc = 0; dec = 0; fast = 0; setval = 0; clr_episodes = 0;
        rst_n = 1'b0;
        ma = m_reset(pa);
        mb = m_reset(pb);
        #1;
        check("reset.b.active_async", int'(active_b), 0);
        check("reset.b.state_async", int'(state_b), 0);
        @(posedge clk);
        sb.push_back(to_exp(0, ma));
        sb.push_back(to_exp(1, mb));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pa = '{9, 128, 128, 4, 384, 127, 1, 0, 8};
        pb = '{9, 128, 128, 4, 384, 380, 3, 10, 4};
        ma = m_reset(pa);
        mb = m_reset(pb);
        @(negedge clk);
        do_reset();

        // Idle after reset, then climb 380 -> 384 and watch the onset.
        idle(5);
        check("idle.level", int'(level_a), 128);
        check("idle.active", int'(active_a), 0);
        check("idle.episodes", int'(episodes_a), 0);
        cycle(0, 0, 0, 1, 0);
        ramp_up(63);
        check("climb.level380", int'(level_a), 380);
        ramp_up(1);
        check("climb.level384", int'(level_a), 384);
        check("climb.not_yet_active", int'(active_a), 0);
        idle(1);
        check("onset.active", int'(active_a), 1);
        check("onset.pulse", int'(onset_p_a), 1);
        check("onset.episodes", int'(episodes_a), 1);
        idle(1);
        check("onset.pulse_single", int'(onset_p_a), 0);

        // Saturation at both ends and inc+dec hold.
        ramp_up(200);
        check("sat.top", int'(level_a), 511);
        ramp_down(200);
        check("sat.bottom", int'(level_a), 0);
        cycle(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1, 1, 0, 0);
        check("incdec.hold", int'(level_a), 128);

        // Dwell: 384/383 toggling never turns the debounced instance on.
        do_reset();
        ramp_up(63);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0, 0, 0);
            cycle(0, 1, 0, 0, 0);
        end
        check("dwell.toggle_inactive", int'(active_b), 0);
        cycle(1, 0, 0, 0, 0);
        idle(2);
        check("dwell.after2", int'(active_b), 0);
        idle(1);
        check("dwell.after3", int'(active_b), 1);

        // Minimum hold: drop straight below the exit threshold.
        ramp_down(12);
        check("hold.still_active", int'(active_b), 1);
        ramp_down(1);
        check("hold.released", int'(active_b), 0);
        check("hold.recover_pulse", int'(recover_p_b), 1);

        // Hysteresis: parking between thresholds keeps the current state.
        do_reset();
        ramp_up(64);
        idle(2);
        ramp_down(46);
        idle(50);
        check("hyst.level200", int'(level_a), 200);
        check("hyst.stays_active", int'(active_a), 1);
        do_reset();
        cycle(0, 0, 0, 1, 0);
        ramp_up(18);
        idle(50);
        check("hyst.stays_idle", int'(active_a), 0);

        // Reset while the debounced instance is in RECOVER.
        do_reset();
        ramp_up(64);
        for (int k = 0; k < 20 && !mb.act; k++) idle(1);
        for (int k = 0; k < 40 && !(mb.act && mb.run > 0); k++) ramp_down(1);
        do_reset();
        idle(3);

        // Episode saturation, then clear coinciding with an onset.
        for (int n = 0; n < 256; n++) begin
            cycle(0, 0, 0, 1, 0);
            ramp_up(64);
            idle(4);
            ramp_down(70);
            idle(2);
        end
        check("epi.sat_a", int'(episodes_a), 255);
        check("epi.sat_b", int'(episodes_b), 15);
        cycle(0, 0, 0, 1, 0);
        ramp_up(64);
        cycle(0, 0, 0, 0, 1);
        check("epi.clr_onset", int'(episodes_a), 1);
        idle(4);

        // Randomised phases alternating upward and downward bias.
        for (int ph = 0; ph < 40; ph++) begin
            bit up;
            up = 1'($urandom_range(0, 1));
            for (int k = 0; k < 100; k++) begin
                int r;
                bit i, d;
                r = $urandom_range(0, 99);
                i = up ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
                d = up ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
                cycle(i, d, 1'($urandom_range(0, 1)), r < 2, r >= 97);
            end
        end

        @(negedge clk);
        check("scoreboard.drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
